// File: rtl/aes_pkg.sv
// Shared AES types, S-box table, round constants and GF(2^8) column helpers
// used by the iterative AES-256 encryption core.
package aes_pkg;

  typedef logic [15:0][7:0] state_t;
  typedef logic [3:0][7:0]  word_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fsm_t;

  localparam int NR = 14;

  localparam logic [7:0] RCON [0:6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  // Entry x sits at bits [2047-8x -: 8], i.e. the table reads left to right.
  localparam logic [2047:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // w[3] is row 0 of the column.
  function automatic word_t mixcol(input word_t w);
    word_t r;
    r[3] = xtime(w[3]) ^ xtime(w[2]) ^ w[2] ^ w[1] ^ w[0];
    r[2] = w[3] ^ xtime(w[2]) ^ xtime(w[1]) ^ w[1] ^ w[0];
    r[1] = w[3] ^ w[2] ^ xtime(w[1]) ^ xtime(w[0]) ^ w[0];
    r[0] = xtime(w[3]) ^ w[3] ^ w[2] ^ w[1] ^ xtime(w[0]);
    return r;
  endfunction

  function automatic logic [7:0] rcon_f(input logic [2:0] idx);
    if (idx < 3'd7) begin
      return RCON[idx];
    end else begin
      return 8'h00;
    end
  endfunction

endpackage

// File: rtl/aes256_enc_core_if.sv
// Register-write and ciphertext bus between the AXI slave wrapper (master)
// and the AES-256 encryption core (slave).
interface aes256_enc_core_if;
  logic             req_axi_in;
  logic             addr;
  logic [15:0][7:0] plaintext;
  logic [15:0][7:0] encData;
  logic             done;

  modport master (output req_axi_in, addr, plaintext, input encData, done);
  modport slave  (input req_axi_in, addr, plaintext, output encData, done);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup for a single byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Offset 8*(255-x) equals {~x, 3'b000}.
  assign out_o = SBOX[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes256_enc_core.sv
// Iterative AES-256 encryption core: one round per clock, round keys expanded on the fly.
// Optional feature macro AES256_ENC_KEYLOAD_EN adds a host-loadable 256-bit key register.
module aes256_enc_core #(
  parameter logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
  parameter int           NR  = aes_pkg::NR
) (
  input logic              clk,
  input logic              resetn,
  aes256_enc_core_if.slave bus
);
  import aes_pkg::*;

  fsm_t         fsm_q;
  logic [3:0]   round_q;
  state_t       state_q;
  state_t       enc_q;
  logic [127:0] buf_q;
  logic [127:0] ka_q;
  logic [127:0] kb_q;
  logic [2:0]   cnt_q;
  logic         start_q;
  logic         done_q;

  logic [255:0] key_s;
  logic [31:0]  wdata_s;
  logic         data_we_s;
  logic         ctrl_we_s;
  logic         full_s;
  logic         go_s;
  logic         last_s;
  logic         unused_s;

  state_t       sub_s;
  state_t       sr_s;
  state_t       mc_s;
  state_t       rnd_s;
  logic [127:0] ksa_s;
  logic [127:0] ksb_s;
  logic [127:0] kn_s;
  logic [31:0]  sw_s;
  logic [31:0]  temp_s;
  logic [31:0]  n0_s;
  logic [31:0]  n1_s;
  logic [31:0]  n2_s;
  logic [3:0]   ksr_s;

  assign wdata_s   = bus.plaintext[3:0];
  assign unused_s  = ^bus.plaintext[15:4];
  assign data_we_s = bus.req_axi_in & bus.addr & (fsm_q != BUSY);
  assign ctrl_we_s = bus.req_axi_in & ~bus.addr;
  assign full_s    = (cnt_q == 3'd4);
  assign last_s    = (round_q == 4'(NR));

`ifdef AES256_ENC_KEYLOAD_EN
  logic         keymode_q;
  logic [255:0] key_q;

  assign key_s = key_q;
  assign go_s  = start_q & full_s & ~keymode_q;

  // Key-load mode flag and the shift-in key register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keymode_q <= 1'b0;
      key_q     <= KEY;
    end else begin
      if (ctrl_we_s) begin
        keymode_q <= wdata_s[1];
      end
      if (data_we_s && keymode_q) begin
        key_q <= {key_q[223:0], wdata_s};
      end
    end
  end
`else
  assign key_s = KEY;
  assign go_s  = start_q & full_s;
`endif

  for (genvar g = 0; g < 16; g++) begin : g_sub
    aes_sbox u_sbox (.in_i(state_q[g]), .out_o(sub_s[g]));
  end

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (.in_i(ksb_s[8*g +: 8]), .out_o(sw_s[8*g +: 8]));
  end

  // Next 4 schedule words from the current round-key pair; the whitening step seeds from the cipher key.
  always_comb begin
    if (fsm_q == BUSY) begin
      ksa_s = ka_q;
      ksb_s = kb_q;
      ksr_s = round_q;
    end else begin
      ksa_s = key_s[255:128];
      ksb_s = key_s[127:0];
      ksr_s = 4'd0;
    end
    // Even step starts a new 8-word group (RotWord + Rcon); odd step is the mid-group SubWord.
    if (!ksr_s[0]) begin
      temp_s = {sw_s[23:0], sw_s[31:24]} ^ {rcon_f(ksr_s[3:1]), 24'h000000};
    end else begin
      temp_s = sw_s;
    end
    n0_s = ksa_s[127:96] ^ temp_s;
    n1_s = ksa_s[95:64]  ^ n0_s;
    n2_s = ksa_s[63:32]  ^ n1_s;
    kn_s = {n0_s, n1_s, n2_s, ksa_s[31:0] ^ n2_s};
  end

  // ShiftRows, MixColumns and AddRoundKey on the substituted state; FIPS byte b lives at index 15-b.
  always_comb begin
    sr_s  = '0;
    mc_s  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[15-(4*c+r)] = sub_s[15-(4*((c+r)%4)+r)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      {mc_s[15-4*c], mc_s[14-4*c], mc_s[13-4*c], mc_s[12-4*c]} =
        mixcol({sr_s[15-4*c], sr_s[14-4*c], sr_s[13-4*c], sr_s[12-4*c]});
    end
    if (last_s) begin
      rnd_s = sr_s ^ ka_q;
    end else begin
      rnd_s = mc_s ^ ka_q;
    end
  end

  // Control capture, plaintext buffer, round FSM and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      enc_q   <= '0;
      buf_q   <= 128'h0;
      ka_q    <= 128'h0;
      kb_q    <= 128'h0;
      cnt_q   <= 3'd0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= ctrl_we_s & wdata_s[0];
      if (data_we_s) begin
        done_q <= 1'b0;
`ifdef AES256_ENC_KEYLOAD_EN
        if (!keymode_q) begin
          buf_q <= {buf_q[95:0], wdata_s};
          cnt_q <= full_s ? 3'd4 : cnt_q + 3'd1;
        end
`else
        buf_q <= {buf_q[95:0], wdata_s};
        cnt_q <= full_s ? 3'd4 : cnt_q + 3'd1;
`endif
      end
      case (fsm_q)
        IDLE: begin
          if (go_s) begin
            state_q <= buf_q ^ key_s[255:128];
            ka_q    <= key_s[127:0];
            kb_q    <= kn_s;
            round_q <= 4'd1;
            cnt_q   <= 3'd0;
            fsm_q   <= BUSY;
          end
        end
        BUSY: begin
          state_q <= rnd_s;
          ka_q    <= kb_q;
          kb_q    <= kn_s;
          round_q <= round_q + 4'd1;
          if (last_s) begin
            enc_q  <= rnd_s;
            done_q <= 1'b1;
            fsm_q  <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.encData = enc_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_aes256_enc_core.sv
// Self-checking bench for aes256_enc_core: directed FIPS vectors plus random runs
// compared against a byte-array AES-256 model whose S-box is derived from GF(2^8) inversion.
module tb_aes256_enc_core;

  localparam logic [255:0] KEY_DEF = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_K0   = 128'hdc95c078a2408989ad48a21492842087;

  logic       clk = 1'b0;
  logic       resetn;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] sbox_tab [0:255];

  aes256_enc_core_if bus_a ();
  aes256_enc_core_if bus_z ();

  aes256_enc_core dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  aes256_enc_core #(.KEY(256'h0)) dut_z (.clk(clk), .resetn(resetn), .bus(bus_z));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] p;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        p = 8'h01;
        for (int k = 0; k < 254; k++) p = gmul(p, 8'(x));
        inv = p;
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [255:0] key, input logic [127:0] pt);
    logic [7:0]   w   [0:239];
    logic [7:0]   s   [0:15];
    logic [7:0]   t   [0:15];
    logic [7:0]   tmp [0:3];
    logic [7:0]   rc;
    logic [7:0]   x;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 32; i++) w[i] = key[255-8*i -: 8];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 8 == 0) begin
        x      = tmp[0];
        tmp[0] = sbox_tab[tmp[1]] ^ rc;
        tmp[1] = sbox_tab[tmp[2]];
        tmp[2] = sbox_tab[tmp[3]];
        tmp[3] = sbox_tab[x];
        rc     = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbox_tab[tmp[j]];
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-8)+j] ^ tmp[j];
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b];
    for (int r = 1; r <= 14; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sbox_tab[s[b]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[16*r+b];
    end
    for (int b = 0; b < 16; b++) ct[127-8*b -: 8] = s[b];
    return ct;
  endfunction

  // ---------------- bus access ----------------
  task automatic drive(input int sel, input logic req, input logic a, input logic [31:0] d);
    if (sel == 0) begin
      bus_a.req_axi_in = req;
      bus_a.addr       = a;
      bus_a.plaintext  = {96'h0, d};
    end else begin
      bus_z.req_axi_in = req;
      bus_z.addr       = a;
      bus_z.plaintext  = {96'h0, d};
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus_a.done : bus_z.done;
  endfunction

  function automatic logic [127:0] get_enc(input int sel);
    return (sel == 0) ? bus_a.encData : bus_z.encData;
  endfunction

  task automatic wr(input int sel, input logic a, input logic [31:0] d);
    @(negedge clk);
    drive(sel, 1'b1, a, d);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic load4(input int sel, input logic [127:0] pt);
    wr(sel, 1'b1, pt[127:96]);
    wr(sel, 1'b1, pt[95:64]);
    wr(sel, 1'b1, pt[63:32]);
    wr(sel, 1'b1, pt[31:0]);
  endtask

  task automatic wait_done(input int sel, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (get_done(sel)) begin
        cyc = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    checks++; if (bus_a.encData !== 128'h0) begin failures++; $display("FAIL reset_enc: got %h expected 0", bus_a.encData); end
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus_a.done); end
    checks++; if (bus_z.encData !== 128'h0) begin failures++; $display("FAIL reset_enc_z: got %h expected 0", bus_z.encData); end
    checks++; if (bus_z.done !== 1'b0) begin failures++; $display("FAIL reset_done_z: got %b expected 0", bus_z.done); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_fips();
    load4(0, PT_C3);
    wr(0, 1'b0, 32'h1);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++;
      if (bus_a.done !== (i == 15)) begin
        failures++; $display("FAIL fips_done_timing cycle %0d: got %b expected %b", i, bus_a.done, (i == 15));
      end
    end
    checks++; if (bus_a.encData !== CT_C3) begin failures++; $display("FAIL fips_enc: got %h expected %h", bus_a.encData, CT_C3); end
  endtask

  task automatic test_done_clear();
    wr(0, 1'b1, $urandom);
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL done_clear: got %b expected 0", bus_a.done); end
    checks++; if (bus_a.encData !== CT_C3) begin failures++; $display("FAIL done_clear_hold: got %h expected %h", bus_a.encData, CT_C3); end
  endtask

  task automatic test_busy_protect();
    load4(0, PT_C3);
    wr(0, 1'b0, 32'h1);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++;
      if (bus_a.done !== (i == 15)) begin
        failures++; $display("FAIL busy_done_timing cycle %0d: got %b expected %b", i, bus_a.done, (i == 15));
      end
      if (i >= 2 && i <= 10) begin
        if (i % 2 == 1) drive(0, 1'b1, 1'b1, $urandom);
        else            drive(0, 1'b1, 1'b0, 32'h1);
      end else begin
        drive(0, 1'b0, 1'b0, 32'h0);
      end
    end
    checks++; if (bus_a.encData !== CT_C3) begin failures++; $display("FAIL busy_enc: got %h expected %h", bus_a.encData, CT_C3); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    load4(0, {$urandom, $urandom, $urandom, $urandom});
    wr(0, 1'b0, 32'h1);
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++; if (bus_a.encData !== 128'h0) begin failures++; $display("FAIL midreset_enc: got %h expected 0", bus_a.encData); end
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b expected 0", bus_a.done); end
    @(negedge clk);
    resetn = 1'b1;
    load4(0, PT_C3);
    wr(0, 1'b0, 32'h1);
    wait_done(0, cyc);
    checks++; if (cyc != 15) begin failures++; $display("FAIL midreset_latency: got %0d expected 15", cyc); end
    checks++; if (bus_a.encData !== CT_C3) begin failures++; $display("FAIL midreset_rerun: got %h expected %h", bus_a.encData, CT_C3); end
  endtask

  task automatic test_incomplete();
    logic [31:0] w0, w1, w2, w3;
    logic [127:0] exp;
    int cyc;
    w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
    wr(0, 1'b1, w0); wr(0, 1'b1, w1); wr(0, 1'b1, w2);
    wr(0, 1'b0, 32'h1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus_a.done !== 1'b0) begin failures++; $display("FAIL incomplete_done cycle %0d: got %b expected 0", i, bus_a.done); end
    end
    wr(0, 1'b1, w3);
    wr(0, 1'b0, 32'h1);
    wait_done(0, cyc);
    exp = ref_encrypt(KEY_DEF, {w0, w1, w2, w3});
    checks++; if (cyc != 15) begin failures++; $display("FAIL incomplete_latency: got %0d expected 15", cyc); end
    checks++; if (bus_a.encData !== exp) begin failures++; $display("FAIL incomplete_enc: got %h expected %h", bus_a.encData, exp); end
  endtask

  task automatic test_key_zero();
    int cyc;
    load4(1, 128'h0);
    wr(1, 1'b0, 32'h1);
    wait_done(1, cyc);
    checks++; if (cyc != 15) begin failures++; $display("FAIL key0_latency: got %0d expected 15", cyc); end
    checks++; if (bus_z.encData !== CT_K0) begin failures++; $display("FAIL key0_enc: got %h expected %h", bus_z.encData, CT_K0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  q [$];
    logic [31:0]  w;
    logic [127:0] pt, exp;
    int           sel, n, cyc;
    for (int it = 0; it < 6; it++) begin
      sel = it % 2;
      n   = 4 + int'($urandom_range(0, 2));
      q.delete();
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        q.push_back(w);
        wr(sel, 1'b1, w);
        if (k == 0) begin
          checks++;
          if (get_done(sel) !== 1'b0) begin failures++; $display("FAIL b2b_done_clear it%0d: got %b expected 0", it, get_done(sel)); end
        end
      end
      pt = {q[n-4], q[n-3], q[n-2], q[n-1]};
      exp = ref_encrypt((sel == 0) ? KEY_DEF : 256'h0, pt);
      wr(sel, 1'b0, 32'h1);
      wait_done(sel, cyc);
      checks++; if (cyc != 15) begin failures++; $display("FAIL b2b_latency it%0d: got %0d expected 15", it, cyc); end
      checks++;
      if (get_enc(sel) !== exp) begin failures++; $display("FAIL b2b_enc it%0d: got %h expected %h", it, get_enc(sel), exp); end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_done_clear();
    test_busy_protect();
    test_reset_mid();
    test_incomplete();
    test_key_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
